// File: rtl/ex_wb.sv
// ex_wb: execute/write-back stage of the 3-stage 16-bit pipeline.
// Single-cycle ALU ops write the register file one cycle after acceptance.
// Define EX_MUL_EN to build the optional iterative shift-add multiplier
// (opcode 8). It takes WIDTH cycles and holds decode/fetch through stall.
// Without EX_MUL_EN, opcode 8 behaves as an undefined opcode and stall is 0.
module ex_wb #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [3:0]       opcode,
    input  logic [3:0]       rd,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    output logic             stall,
    output logic             wb_en,
    output logic [1:0]       wb_addr,
    output logic [WIDTH-1:0] wb_data,
    output logic             flag_z,
    output logic             flag_c
);

    logic             accept;
    logic             rd_ok;
    logic             alu_sel;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             mul_done;
    logic             mul_wr;
    logic [1:0]       mul_addr;
    logic [WIDTH-1:0] mul_res;

    assign accept = in_valid & ~stall;
    // Destinations 4..15 do not exist: compute and set flags, but never write.
    assign rd_ok  = (rd[3:2] == 2'b00);

    // Single-cycle ALU: result, carry/borrow and whether the opcode is an ALU op
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_sel = accept;
        case (opcode)
            4'd1:    {alu_c, alu_res} = {1'b0, data1} + {1'b0, data2};
            4'd2:    {alu_c, alu_res} = {1'b0, data1} - {1'b0, data2};
            4'd3:    alu_res = data1 & data2;
            4'd4:    alu_res = data1 | data2;
            4'd5:    alu_res = data1 ^ data2;
            4'd6:    alu_res = data1 << data2[3:0];
            4'd7:    alu_res = data1 >> data2[3:0];
            default: alu_sel = 1'b0;
        endcase
    end

`ifdef EX_MUL_EN
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, MUL} state_t;

    state_t           state;
    logic [WIDTH-1:0] mul_a;
    logic [WIDTH-1:0] mul_b;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [CNT_W-1:0] count;

    assign acc_next = acc + (mul_b[0] ? mul_a : '0);
    // The last iteration's sum goes straight to write-back on the same edge.
    assign mul_done = (state == MUL) && (count == CNT_W'(1));
    assign mul_res  = acc_next;

    // Multiplier sequencer: latch operands on acceptance, one shift-add per edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            stall    <= 1'b0;
            count    <= '0;
            acc      <= '0;
            mul_a    <= '0;
            mul_b    <= '0;
            mul_wr   <= 1'b0;
            mul_addr <= '0;
        end else if (state == IDLE) begin
            if (accept && opcode == 4'd8) begin
                state    <= MUL;
                stall    <= 1'b1;
                count    <= CNT_W'(WIDTH);
                acc      <= '0;
                mul_a    <= data1;
                mul_b    <= data2;
                mul_wr   <= rd_ok;
                mul_addr <= rd[1:0];
            end
        end else begin
            acc   <= acc_next;
            mul_a <= mul_a << 1;
            mul_b <= mul_b >> 1;
            count <= count - CNT_W'(1);
            if (count == CNT_W'(1)) begin
                state <= IDLE;
                stall <= 1'b0;
            end
        end
    end
`else
    assign stall    = 1'b0;
    assign mul_done = 1'b0;
    assign mul_wr   = 1'b0;
    assign mul_addr = '0;
    assign mul_res  = '0;
`endif

    // Write-back strobe, held address/data and flags
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_en   <= 1'b0;
            wb_addr <= '0;
            wb_data <= '0;
            flag_z  <= 1'b0;
            flag_c  <= 1'b0;
        end else begin
            wb_en <= 1'b0;
            if (alu_sel) begin
                wb_en <= rd_ok;
                if (rd_ok) begin
                    wb_addr <= rd[1:0];
                    wb_data <= alu_res;
                end
                flag_z <= (alu_res == '0);
                flag_c <= alu_c;
            end else if (mul_done) begin
                wb_en <= mul_wr;
                if (mul_wr) begin
                    wb_addr <= mul_addr;
                    wb_data <= mul_res;
                end
                flag_z <= (mul_res == '0);
                flag_c <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ex_wb.sv
// tb_ex_wb: directed bench for ex_wb with a cycle-stamped write scoreboard
// and a reference model of stall and flags, compared every cycle.
module tb_ex_wb;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [3:0]  opcode;
    logic [3:0]  rd;
    logic [15:0] data1;
    logic [15:0] data2;
    logic        stall;
    logic        wb_en;
    logic [1:0]  wb_addr;
    logic [15:0] wb_data;
    logic        flag_z;
    logic        flag_c;

    ex_wb #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .opcode   (opcode),
        .rd       (rd),
        .data1    (data1),
        .data2    (data2),
        .stall    (stall),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .flag_z   (flag_z),
        .flag_c   (flag_c)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [1:0]  addr;
        logic [15:0] data;
    } wr_t;

    wr_t         sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          mul_end = 0;
    int          stall_cnt = 0;
    logic        mdl_stall = 1'b0;
    logic        mdl_z = 1'b0;
    logic        mdl_c = 1'b0;
    logic        mul_active = 1'b0;
    logic [15:0] mul_prod = '0;
    logic [1:0]  mdl_addr = '0;
    logic [15:0] mdl_data = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic set_in(input logic v, input logic [3:0] op, input logic [3:0] d,
                          input logic [15:0] a, input logic [15:0] b);
        in_valid = v;
        opcode   = op;
        rd       = d;
        data1    = a;
        data2    = b;
    endtask

    // Reference for single-cycle ops; returns 0 for opcodes that do nothing.
    function automatic logic ref_op(input logic [3:0] op, input logic [15:0] a,
                                    input logic [15:0] b, output logic [15:0] r,
                                    output logic c);
        logic [16:0] t;
        logic        ok;
        r  = '0;
        c  = 1'b0;
        ok = 1'b1;
        case (op)
            4'd1: begin
                t = {1'b0, a} + {1'b0, b};
                r = t[15:0];
                c = t[16];
            end
            4'd2: begin
                r = a - b;
                c = (a < b);
            end
            4'd3: r = a & b;
            4'd4: r = a | b;
            4'd5: r = a ^ b;
            4'd6: r = a << b[3:0];
            4'd7: r = a >> b[3:0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Advance one clock: update the model for what the edge should accept,
    // then compare every output in the following cycle.
    task automatic step();
        logic [15:0] r;
        logic        c;
        logic        ok;
        logic        hit;
        logic [31:0] p;
        wr_t         e;
        if (rst) begin
            sb.delete();
            mul_active = 1'b0;
            mdl_z      = 1'b0;
            mdl_c      = 1'b0;
            mdl_addr   = '0;
            mdl_data   = '0;
        end else if (in_valid && !mdl_stall) begin
            ok = ref_op(opcode, data1, data2, r, c);
            if (ok) begin
                mdl_z = (r == 16'h0);
                mdl_c = c;
                if (rd[3:2] == 2'b00) sb.push_back('{cyc + 1, rd[1:0], r});
            end
`ifdef EX_MUL_EN
            else if (opcode == 4'd8) begin
                p          = 32'(data1) * 32'(data2);
                mul_prod   = p[15:0];
                mul_active = 1'b1;
                mul_end    = cyc + 17;
                if (rd[3:2] == 2'b00) sb.push_back('{cyc + 17, rd[1:0], p[15:0]});
            end
`endif
        end
        @(posedge clk);
        cyc++;
        #1;
        if (mul_active && cyc == mul_end) begin
            mdl_z      = (mul_prod == 16'h0);
            mdl_c      = 1'b0;
            mul_active = 1'b0;
        end
        mdl_stall = mul_active;
        hit = (sb.size() > 0) && (sb[0].cyc == cyc);
        chk("stall", 32'(stall), 32'(mdl_stall));
        chk("wb_en", 32'(wb_en), 32'(hit));
        if (hit) begin
            e        = sb.pop_front();
            mdl_addr = e.addr;
            mdl_data = e.data;
        end
        chk("wb_addr", 32'(wb_addr), 32'(mdl_addr));
        chk("wb_data", 32'(wb_data), 32'(mdl_data));
        chk("flag_z", 32'(flag_z), 32'(mdl_z));
        chk("flag_c", 32'(flag_c), 32'(mdl_c));
    endtask

    initial begin
        rst = 1'b1;
        set_in(1'b0, 4'd0, 4'd0, 16'h0, 16'h0);
        step();
        step();
        chk("reset_stall", 32'(stall), 32'h0);
        chk("reset_wb_data", 32'(wb_data), 32'h0);
        rst = 1'b0;
        step();

        // ADD with carry out and zero result
        set_in(1'b1, 4'd1, 4'd1, 16'hFFFF, 16'h0001);
        step();
        chk("add_wb_en", 32'(wb_en), 32'h1);
        chk("add_addr", 32'(wb_addr), 32'h1);
        chk("add_data", 32'(wb_data), 32'h0);
        chk("add_z", 32'(flag_z), 32'h1);
        chk("add_c", 32'(flag_c), 32'h1);

        // Back-to-back SUB with borrow then XOR
        set_in(1'b1, 4'd2, 4'd2, 16'h0003, 16'h0005);
        step();
        chk("sub_data", 32'(wb_data), 32'hFFFE);
        chk("sub_c", 32'(flag_c), 32'h1);
        set_in(1'b1, 4'd5, 4'd3, 16'hF0F0, 16'hFFFF);
        step();
        chk("xor_wb_en", 32'(wb_en), 32'h1);
        chk("xor_data", 32'(wb_data), 32'h0F0F);
        chk("xor_z", 32'(flag_z), 32'h0);
        chk("xor_c", 32'(flag_c), 32'h0);
        set_in(1'b0, 4'd0, 4'd0, 16'h0, 16'h0);
        step();

        // SHL uses only B[3:0]; ADD to rd=5 updates flags without writing
        set_in(1'b1, 4'd6, 4'd0, 16'h0001, 16'h0013);
        step();
        chk("shl_data", 32'(wb_data), 32'h0008);
        set_in(1'b1, 4'd1, 4'd5, 16'hFFFF, 16'hFFFF);
        step();
        chk("rd5_wb_en", 32'(wb_en), 32'h0);
        chk("rd5_hold_data", 32'(wb_data), 32'h0008);
        chk("rd5_c", 32'(flag_c), 32'h1);

        // Further patterns, including NOP and an undefined opcode
        set_in(1'b1, 4'd3, 4'd1, 16'hF0F0, 16'h0F0F);
        step();
        set_in(1'b1, 4'd4, 4'd2, 16'h1234, 16'h00FF);
        step();
        set_in(1'b1, 4'd7, 4'd3, 16'h8000, 16'h001F);
        step();
        chk("shr_data", 32'(wb_data), 32'h0001);
        set_in(1'b1, 4'd2, 4'd0, 16'h0005, 16'h0005);
        step();
        set_in(1'b1, 4'd0, 4'd1, 16'hAAAA, 16'h5555);
        step();
        set_in(1'b1, 4'd12, 4'd2, 16'h0000, 16'h0000);
        step();
        chk("undef_z_hold", 32'(flag_z), 32'h1);
        set_in(1'b0, 4'd0, 4'd0, 16'h0, 16'h0);
        step();

        // MUL with the next instruction held valid behind it
        set_in(1'b1, 4'd8, 4'd2, 16'h8001, 16'h0003);
        step();
        set_in(1'b1, 4'd1, 4'd3, 16'h0001, 16'h0002);
        stall_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            if (stall) stall_cnt++;
            step();
        end
`ifdef EX_MUL_EN
        chk("mul_stall_cycles", 32'(stall_cnt), 32'd16);
        chk("mul_wb_en", 32'(wb_en), 32'h1);
        chk("mul_data", 32'(wb_data), 32'h8003);
        chk("mul_stall_end", 32'(stall), 32'h0);
        step();
        chk("after_mul_data", 32'(wb_data), 32'h0003);
`else
        chk("nomul_stall_cycles", 32'(stall_cnt), 32'd0);
        step();
`endif
        set_in(1'b0, 4'd0, 4'd0, 16'h0, 16'h0);
        step();

        // Reset in the middle of a MUL, with in_valid toggling while stalled
        set_in(1'b1, 4'd8, 4'd1, 16'h0005, 16'h0007);
        step();
        for (int i = 0; i < 4; i++) begin
            set_in(i[0], 4'd1, 4'd2, 16'h0100, 16'(i));
            step();
        end
        rst = 1'b1;
        set_in(1'b0, 4'd0, 4'd0, 16'h0, 16'h0);
        step();
        chk("rst_mid_stall", 32'(stall), 32'h0);
        chk("rst_mid_wb_en", 32'(wb_en), 32'h0);
        rst = 1'b0;
        set_in(1'b1, 4'd1, 4'd1, 16'h7FFF, 16'h0001);
        step();
        chk("post_rst_data", 32'(wb_data), 32'h8000);
        chk("post_rst_c", 32'(flag_c), 32'h0);
        chk("post_rst_z", 32'(flag_z), 32'h0);

        // MUL to an out-of-range destination with a zero product
        set_in(1'b1, 4'd8, 4'd6, 16'h0000, 16'h0005);
        step();
        set_in(1'b0, 4'd0, 4'd0, 16'h0, 16'h0);
        for (int i = 0; i < 18; i++) step();

        chk("scoreboard_empty", 32'(sb.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_wb.md
# ex_wb

Execute/write-back stage of the 3-stage 16-bit pipeline, directly downstream of instruction decode. It consumes the decoded opcode, destination index and the two registered source operands, computes the result, and issues a one-cycle write to the 4-entry register file. Single-cycle ALU operations complete in one cycle. An optional iterative multiplier takes 16 cycles and back-pressures decode and fetch through `stall`.

## Interface
Parameters:
- `WIDTH`, default 16: datapath width; the multiplier iteration count equals `WIDTH`.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `in_valid` input 1: decode presents a valid instruction this cycle.
- `opcode` input 4: operation, `instr_id[15:12]`.
- `rd` input 4: destination index, `instr_id[11:8]`.
- `data1` input WIDTH: operand A, the value read at `rs1`.
- `data2` input WIDTH: operand B, the value read at `rs2`.
- `stall` output 1: registered; decode and fetch hold their state while it is high.
- `wb_en` output 1: register-file write strobe, one cycle per write.
- `wb_addr` output 2: write index, equal to `rd[1:0]`.
- `wb_data` output WIDTH: write data.
- `flag_z` output 1: zero flag of the last flag-updating operation.
- `flag_c` output 1: carry/borrow flag of the last flag-updating operation.

## Operation
- An instruction is accepted on a rising edge when `in_valid` is 1 and `stall` is 0. Inputs are ignored while `stall` is 1.
- Opcode map:
  - 0: NOP.
  - 1: ADD, A+B.
  - 2: SUB, A−B.
  - 3: AND.
  - 4: OR.
  - 5: XOR.
  - 6: SHL, A << B[3:0].
  - 7: SHR, A >> B[3:0], logical shift with zero fill.
  - 8: MUL, low WIDTH bits of A*B.
  - 9–15: treated as NOP.
- NOP and undefined opcodes:
  - No write.
  - Flags unchanged.
  - No stall.
- Arithmetic is modulo 2^WIDTH.
  - ADD: `flag_c` is the carry out of the top bit.
  - SUB: `flag_c` is 1 when there is a borrow, i.e. A < B unsigned.
  - All other ops clear `flag_c`.
- `flag_z` = (result == 0).
- Flags update on every accepted opcode from 1 to 8, including when `rd` ≥ 4.
- Write-back:
  - `rd[3:2]` ≠ 0 means the destination is out of range. The result is computed and flags update, but `wb_en` stays 0.
  - Otherwise `wb_addr` = `rd[1:0]`.
- Multiply state machine, states IDLE and MUL:
  - IDLE→MUL on acceptance of opcode 8. The block latches A and B, clears the accumulator, sets `stall`=1 and loads the count with WIDTH.
  - In MUL, each edge does: if B[0] then acc += A; then A <<= 1, B >>= 1, count −= 1.
  - When count reaches 0 the block returns to IDLE, clears `stall`, and pulses `wb_en` with the accumulator as `wb_data`.
- `wb_addr` and `wb_data` hold their last value when `wb_en` is 0.

## Timing
- Reset values:
  - `stall`=0, `wb_en`=0, `wb_addr`=0, `wb_data`=0, `flag_z`=0, `flag_c`=0.
  - State is IDLE; count and accumulator are 0.
- Single-cycle op accepted at edge N: `wb_en`=1 and data and flags are valid during cycle N+1. `wb_en` returns to 0 after one cycle unless a new op is accepted at N+1.
- Back-to-back single-cycle ops give one write per cycle.
- MUL accepted at edge N:
  - `stall`=1 in cycles N+1 through N+16.
  - `wb_en`=1 with the product in cycle N+17, and `stall`=0 in that same cycle.
  - The next instruction can be accepted at edge N+17.
- The edge that accepts a MUL also completes any previous single-cycle write. No write is lost or duplicated.
- Reset asserted mid-multiply:
  - The multiply aborts and no write is issued.
  - `stall` is 0 in the cycle after the reset edge.
- `in_valid` toggling while `stall`=1 has no effect.

## Configuration
- `EX_MUL_EN` defined: the multiplier and the MUL state are present as described above.
- `EX_MUL_EN` undefined:
  - Opcode 8 is treated as an undefined opcode: no write, flags unchanged.
  - `stall` is tied to 0.
  - No multiplier logic is synthesised.

## Test plan
- Reset, then ADD with rd=1, A=0xFFFF, B=0x0001 → cycle N+1: `wb_en`=1, `wb_addr`=1, `wb_data`=0x0000, `flag_z`=1, `flag_c`=1.
- SUB with rd=2, A=0x0003, B=0x0005, immediately followed by XOR with rd=3, A=0xF0F0, B=0xFFFF → consecutive writes:
  - First: 0xFFFE with `flag_c`=1.
  - Second: 0x0F0F with `flag_z`=0, `flag_c`=0.
- SHL with rd=0, A=0x0001, B=0x0013 → `wb_data`=0x0008, since only B[3:0]=3 is used. ADD with rd=5 → `wb_en`=0, but flags still update.
- MUL with rd=2, A=0x8001, B=0x0003, with `in_valid` held high behind it → `stall` high for exactly 16 cycles, then `wb_data`=0x8003 in cycle N+17, and the next instruction is accepted at N+17.
- Reset at cycle N+5 of a MUL → no `wb_en`, and `stall`=0 after the reset edge. A following ADD of 0x7FFF + 0x0001 → 0x8000 with `flag_c`=0.
- Build with `EX_MUL_EN` undefined, issue MUL → `stall` never asserts, no write, flags unchanged.
